// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage between the 24-bit program ROM and the execute stage.
// Optional macro FETCH_RETIRE_COUNT_EN adds the retired_cnt output.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | pulse rom_enable, latch the ROM word, skip NOPs
// S_ISSUE | present latched instruction, wait for instr_ready
// S_HALTED| HALT issued or DEPTH words consumed; only rst leaves
module instr_fetch_decode #(
    parameter int         DEPTH       = 255,
    parameter logic [7:0] HALT_OPCODE = 8'hFF,
    parameter logic [7:0] NOP_OPCODE  = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rom_data,
    output logic        rom_enable,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  opcode,
    output logic [7:0]  op_a,
    output logic [7:0]  op_b,
    output logic        halted,
`ifdef FETCH_RETIRE_COUNT_EN
    output logic [15:0] retired_cnt,
`endif
    output logic        end_of_prog
);

    localparam logic [7:0] DEPTH_CNT = 8'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_ISSUE  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] fetch_cnt;
    logic       latch_en;
    logic       eop_set;

    always_comb begin
        state_nxt   = state;
        rom_enable  = 1'b0;
        instr_valid = 1'b0;
        latch_en    = 1'b0;
        eop_set     = 1'b0;
        case (state)
            S_FETCH: begin
                if (fetch_cnt < DEPTH_CNT) begin
                    rom_enable = 1'b1;
                    latch_en   = 1'b1;
                    if (rom_data[23:16] == NOP_OPCODE) begin
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end else begin
                    state_nxt = S_HALTED;
                    eop_set   = 1'b1;
                end
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    if (opcode == HALT_OPCODE) begin
                        state_nxt = S_HALTED;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // fetch_cnt tracks the ROM pc exactly: both advance only on rom_enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            fetch_cnt   <= 8'd0;
            opcode      <= 8'd0;
            op_a        <= 8'd0;
            op_b        <= 8'd0;
            halted      <= 1'b0;
            end_of_prog <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch_en) begin
                opcode    <= rom_data[23:16];
                op_a      <= rom_data[15:8];
                op_b      <= rom_data[7:0];
                fetch_cnt <= fetch_cnt + 8'd1;
            end
            if (eop_set) begin
                end_of_prog <= 1'b1;
            end
            if (state == S_HALTED) begin
                halted <= 1'b1;
            end
        end
    end

`ifdef FETCH_RETIRE_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= 16'd0;
        end else if (instr_valid && instr_ready && (retired_cnt != 16'hFFFF)) begin
            retired_cnt <= retired_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: ROM model, table vectors, reset corner case
// and randomized programs checked against a program-level reference model.
module tb_instr_fetch_decode;

    localparam int DEPTH = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] rom_data;
    logic        rom_enable;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  opcode;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        halted;
    logic        end_of_prog;
`ifdef FETCH_RETIRE_COUNT_EN
    logic [15:0] retired_cnt;
`endif

    instr_fetch_decode dut (
        .clk        (clk),
        .rst        (rst),
        .rom_data   (rom_data),
        .rom_enable (rom_enable),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .opcode     (opcode),
        .op_a       (op_a),
        .op_b       (op_b),
        .halted     (halted),
`ifdef FETCH_RETIRE_COUNT_EN
        .retired_cnt(retired_cnt),
`endif
        .end_of_prog(end_of_prog)
    );

    always #5 clk = ~clk;

    logic [23:0] rom [0:255];
    logic [8:0]  rom_pc;
    int          enable_cnt;

    assign rom_data = rom[rom_pc[7:0]];

    always @(posedge clk) begin
        if (rst) begin
            rom_pc     <= 9'd0;
            enable_cnt <= 0;
        end else if (rom_enable) begin
            rom_pc     <= rom_pc + 9'd1;
            enable_cnt <= enable_cnt + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: records every completed handshake and checks protocol rules.
    logic [23:0] issued [$];
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [23:0] prev_fields = 24'd0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (instr_valid && instr_ready && !rst) issued.push_back({opcode, op_a, op_b});
            chk("enable_with_valid", {31'd0, rom_enable && instr_valid}, 32'd0);
            chk("rom_pc_bound", {31'd0, rom_pc <= 9'(DEPTH)}, 32'd1);
            if (prev_stall && instr_valid)
                chk("stall_hold", {8'd0, opcode, op_a, op_b}, {8'd0, prev_fields});
            prev_stall  = instr_valid && !instr_ready && !rst;
            prev_fields = {opcode, op_a, op_b};
        end
    end

    // Reference model: walk the ROM image as a program.
    logic [23:0] exp_q [$];
    int          exp_en;
    logic        exp_eop;

    function automatic void build_model();
        exp_q.delete();
        exp_en  = 0;
        exp_eop = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_en++;
            if (rom[i][23:16] == 8'h00) continue;
            exp_q.push_back(rom[i]);
            if (rom[i][23:16] == 8'hFF) begin
                exp_eop = 1'b0;
                break;
            end
        end
    endfunction

    logic rand_ready = 1'b0;

    task automatic fill_rom_filler();
        for (int i = 0; i < 256; i++) rom[i] = {8'h11, 8'(i), 8'(i ^ 8'h5A)};
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        issued.delete();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_fields", {8'd0, opcode, op_a, op_b}, 32'd0);
        chk("rst_flags", {30'd0, halted, end_of_prog}, 32'd0);
`ifdef FETCH_RETIRE_COUNT_EN
        chk("rst_retired", {16'd0, retired_cnt}, 32'd0);
`endif
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input int budget);
        int cyc;
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk); #1;
            if (rand_ready) instr_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            cyc++;
            if (halted) break;
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
        if (!halted) $display("FAIL halt_timeout: no halt within %0d cycles", budget);
        #1;
    endtask

    task automatic compare_all(input string tag);
        int n;
        chk({tag, "_issue_count"}, 32'(issued.size()), 32'(exp_q.size()));
        n = (issued.size() < exp_q.size()) ? issued.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_issue"}, {8'd0, issued[i]}, {8'd0, exp_q[i]});
        chk({tag, "_enables"}, 32'(enable_cnt), 32'(exp_en));
        chk({tag, "_eop"}, {31'd0, end_of_prog}, {31'd0, exp_eop});
        chk({tag, "_no_valid_halted"}, {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_RETIRE_COUNT_EN
        chk({tag, "_retired"}, {16'd0, retired_cnt}, 32'(exp_q.size()));
`endif
    endtask

    typedef struct packed {
        logic [3:0][23:0] w;
        int               n;
        int               stall;
        int               exp_lat;
        logic [23:0]      exp_first;
        int               exp_en;
        int               exp_issues;
        logic             exp_eop;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int en_before;

        vecs[0].w[0] = 24'h010203; vecs[0].w[1] = 24'h040506; vecs[0].w[2] = 24'hFF0000;
        vecs[0].w[3] = 24'h000000; vecs[0].n = 3; vecs[0].stall = 0; vecs[0].exp_lat = 1;
        vecs[0].exp_first = 24'h010203; vecs[0].exp_en = 3; vecs[0].exp_issues = 3; vecs[0].exp_eop = 1'b0;
        vecs[1] = vecs[0];
        vecs[1].stall = 5;
        vecs[2].w[0] = 24'h000000; vecs[2].w[1] = 24'h000000; vecs[2].w[2] = 24'h0A0B0C;
        vecs[2].w[3] = 24'hFF0000; vecs[2].n = 4; vecs[2].stall = 0; vecs[2].exp_lat = 3;
        vecs[2].exp_first = 24'h0A0B0C; vecs[2].exp_en = 4; vecs[2].exp_issues = 2; vecs[2].exp_eop = 1'b0;
        vecs[3].w[0] = 24'hFF1234; vecs[3].w[1] = 24'h010101; vecs[3].w[2] = 24'h020202;
        vecs[3].w[3] = 24'h030303; vecs[3].n = 4; vecs[3].stall = 0; vecs[3].exp_lat = 1;
        vecs[3].exp_first = 24'hFF1234; vecs[3].exp_en = 1; vecs[3].exp_issues = 1; vecs[3].exp_eop = 1'b0;

        fill_rom_filler();
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        for (int v = 0; v < 4; v++) begin
            fill_rom_filler();
            for (int i = 0; i < vecs[v].n; i++) rom[i] = vecs[v].w[i];
            build_model();
            rand_ready  = 1'b0;
            instr_ready = (vecs[v].stall == 0);
            do_reset();
            cyc = 0;
            while (cyc < 20) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (instr_valid) break;
            end
            chk("first_latency", 32'(cyc), 32'(vecs[v].exp_lat));
            chk("first_fields", {8'd0, opcode, op_a, op_b}, {8'd0, vecs[v].exp_first});
            en_before = enable_cnt;
            for (int s = 0; s < vecs[v].stall; s++) begin
                @(negedge clk);
                chk("stall_valid", {31'd0, instr_valid}, 32'd1);
                chk("stall_fields", {8'd0, opcode, op_a, op_b}, {8'd0, vecs[v].exp_first});
                chk("stall_no_enable", 32'(enable_cnt), 32'(en_before));
            end
            @(posedge clk); #1;
            instr_ready = 1'b1;
            run_to_halt(100);
            chk("vec_issues", 32'(issued.size()), 32'(vecs[v].exp_issues));
            chk("vec_enables", 32'(enable_cnt), 32'(vecs[v].exp_en));
            chk("vec_eop", {31'd0, end_of_prog}, {31'd0, vecs[v].exp_eop});
            compare_all("vec");
        end

        // Full ROM with no HALT: end of program after DEPTH words.
        for (int i = 0; i < 256; i++) rom[i] = {8'h11, 8'(i), 8'(255 - i)};
        build_model();
        instr_ready = 1'b1;
        do_reset();
        run_to_halt(2000);
        chk("full_issues", 32'(issued.size()), 32'd255);
        chk("full_enables", 32'(enable_cnt), 32'd255);
        chk("full_eop", {31'd0, end_of_prog}, 32'd1);
        compare_all("full");

        // Reset while the third instruction is pending.
        fill_rom_filler();
        rom[0] = 24'h010203; rom[1] = 24'h040506; rom[2] = 24'hFF0000;
        build_model();
        instr_ready = 1'b1;
        do_reset();
        cyc = 0;
        while (issued.size() < 2 && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        instr_ready = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (instr_valid) break;
        end
        chk("pending_third", {8'd0, opcode, op_a, op_b}, 32'h00FF0000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        issued.delete();
        @(negedge clk);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_fields", {8'd0, opcode, op_a, op_b}, 32'd0);
        chk("midrst_halted", {31'd0, halted}, 32'd0);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        run_to_halt(100);
        compare_all("midrst");

        // Randomized programs with random back-pressure.
        rand_ready = 1'b1;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 256; i++) begin
                int r;
                r = $urandom_range(0, 15);
                if (r < 4) rom[i] = {8'h00, 16'($urandom)};
                else if (r == 15 && $urandom_range(0, 7) == 0) rom[i] = {8'hFF, 16'($urandom)};
                else rom[i] = {8'($urandom_range(1, 254)), 16'($urandom)};
            end
            build_model();
            do_reset();
            run_to_halt(3000);
            compare_all("rand");
        end
        rand_ready = 1'b0;

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
